bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the 16-bit combinational integer divider. It takes a divider result (quotient or remainder) and produces five packed BCD digits for the display/readout stage. It uses the iterative shift-and-add-3 (double-dabble) method, one bit per clock, behind a start/busy/done handshake.

---
 rtl/bin2bcd_seq.sv | 148 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter using shift-and-add-3
//               (double dabble), one input bit per clock, behind a
//               start/busy/done handshake. Define BIN2BCD_SIGNED_EN to treat
//               the input as two's complement and report the sign on neg_o.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  neg_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = WIDTH + BCD_W;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q,    sr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic               done_q,  done_d;

  // Value actually loaded into the shift register, and its sign.
  logic [WIDTH-1:0]   w_bin_mag;
  logic               w_bin_neg;

`ifdef BIN2BCD_SIGNED_EN
  // Sign is captured at accept time but only published with the result,
  // so neg_o stays stable for the whole conversion.
  logic               neg_pend_q, neg_pend_d;
  logic               neg_q,      neg_d;

  // Two's-complement magnitude; 0x8000 negates to itself, which read as
  // unsigned is the correct magnitude 32768.
  assign w_bin_neg = bin_i[WIDTH-1];
  assign w_bin_mag = w_bin_neg ? (~bin_i + WIDTH'(1)) : bin_i;
  assign neg_o     = neg_q;
`else
  assign w_bin_neg = 1'b0;
  assign w_bin_mag = bin_i;
  assign neg_o     = 1'b0;
`endif

  // Add-3 correction applied to every BCD digit on the pre-shift value.
  logic [SR_W-1:0]    w_adj;
  logic [SR_W-1:0]    w_shift;
  logic               w_unused_msb;

  assign w_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam int LSB = WIDTH + 4 * gi;
    assign w_adj[LSB +: 4] = (sr_q[LSB +: 4] >= 4'd5) ? (sr_q[LSB +: 4] + 4'd3)
                                                       : sr_q[LSB +: 4];
  end

  // The top bit falls off the register; with enough digits it is always 0.
  assign w_shift      = {w_adj[SR_W-2:0], 1'b0};
  assign w_unused_msb = w_adj[SR_W-1];

  assign busy_o = (state_q == CONV);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

  // Next-state and datapath update for the IDLE/CONV sequencer.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = {{BCD_W{1'b0}}, w_bin_mag};
          cnt_d   = '0;
          state_d = CONV;
`ifdef BIN2BCD_SIGNED_EN
          neg_pend_d = w_bin_neg;
`endif
        end
      end
      CONV: begin
        sr_d  = w_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_CNT) begin
          bcd_d   = w_shift[SR_W-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = neg_pend_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any partial conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq. Expected BCD digits are
//               computed with integer division; BIN2BCD_SIGNED_EN selects
//               the signed interpretation in the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] bin_i;
  logic        busy_o;
  logic        done_o;
  logic [19:0] bcd_o;
  logic        neg_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o),
    .neg_o   (neg_o)
  );

  function automatic int unsigned ref_mag(input logic [15:0] v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[15]) return 32'd65536 - 32'(v);
`endif
    return 32'(v);
  endfunction

  function automatic logic ref_neg(input logic [15:0] v);
`ifdef BIN2BCD_SIGNED_EN
    return v[15];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    int unsigned m;
    int unsigned d;
    logic [19:0] r;
    m = ref_mag(v);
    d = 1;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((m / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents start for one edge with the DUT idle.
  task automatic accept(input logic [15:0] v);
    start_i = 1'b1;
    bin_i   = v;
    tick();
    start_i = 1'b0;
    bin_i   = 16'($urandom);
    acc_cyc = cyc;
    chk("busy_after_accept", 32'(busy_o), 32'd1);
  endtask

  // Waits (bounded) for done; reports latency from accept and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_n);
    int guard;
    guard  = 0;
    busy_n = 0;
    while (done_o !== 1'b1 && guard < 64) begin
      if (busy_o === 1'b1) busy_n++;
      tick();
      guard++;
    end
    lat = cyc - acc_cyc;
    chk("done_seen", 32'(done_o), 32'd1);
  endtask

  task automatic convert_check(input logic [15:0] v);
    int lat;
    int bn;
    accept(v);
    wait_done(lat, bn);
    chk("latency", 32'(lat), 32'd16);
    chk("busy_cycles", 32'(bn), 32'd16);
    chk("busy_in_done", 32'(busy_o), 32'd0);
    chk("bcd", 32'(bcd_o), 32'(ref_bcd(v)));
    chk("neg", 32'(neg_o), 32'(ref_neg(v)));
    tick();
    chk("done_single", 32'(done_o), 32'd0);
    chk("bcd_hold", 32'(bcd_o), 32'(ref_bcd(v)));
  endtask

  initial begin
    int lat;
    int bn;
    int a1;
    int seen;
    logic [15:0] edges [16];

    rst     = 1'b1;
    start_i = 1'b0;
    bin_i   = '0;
    tick(3);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_bcd",  32'(bcd_o),  32'd0);
    chk("rst_neg",  32'(neg_o),  32'd0);
    rst = 1'b0;
    tick(2);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);
    chk("idle_bcd",  32'(bcd_o),  32'd0);

    // Zero input.
    accept(16'd0);
    wait_done(lat, bn);
    chk("zero_lat", 32'(lat), 32'd16);
    chk("zero_bcd", 32'(bcd_o), 32'h00000);
    chk("zero_neg", 32'(neg_o), 32'd0);
    tick();

    // All-ones input.
    accept(16'hFFFF);
    wait_done(lat, bn);
    chk("ffff_busy", 32'(bn), 32'd16);
`ifdef BIN2BCD_SIGNED_EN
    chk("ffff_bcd", 32'(bcd_o), 32'h00001);
    chk("ffff_neg", 32'(neg_o), 32'd1);
`else
    chk("ffff_bcd", 32'(bcd_o), 32'h65535);
    chk("ffff_neg", 32'(neg_o), 32'd0);
`endif
    tick();

    accept(16'd12345);
    wait_done(lat, bn);
    chk("12345_busy", 32'(bn), 32'd16);
    chk("12345_bcd", 32'(bcd_o), 32'h12345);
    tick();

    accept(16'h8000);
    wait_done(lat, bn);
`ifdef BIN2BCD_SIGNED_EN
    chk("8000_bcd", 32'(bcd_o), 32'h32768);
    chk("8000_neg", 32'(neg_o), 32'd1);
`else
    chk("8000_bcd", 32'(bcd_o), 32'h32768);
    chk("8000_neg", 32'(neg_o), 32'd0);
`endif
    tick();

    accept(16'h7FFF);
    wait_done(lat, bn);
    chk("7fff_bcd", 32'(bcd_o), 32'h32767);
    chk("7fff_neg", 32'(neg_o), 32'd0);
    tick();

    // Back-to-back: second start presented during the done cycle.
    accept(16'd9999);
    a1 = acc_cyc;
    wait_done(lat, bn);
    chk("b2b_first_bcd", 32'(bcd_o), 32'h09999);
    accept(16'd10000);
    chk("b2b_accept_gap", 32'(acc_cyc - a1), 32'd17);
    chk("b2b_bcd_held", 32'(bcd_o), 32'h09999);
    wait_done(lat, bn);
    chk("b2b_second_lat", 32'(lat), 32'd16);
    chk("b2b_second_bcd", 32'(bcd_o), 32'h10000);
    tick();

    // Start while busy is ignored.
    accept(16'd4321);
    tick(4);
    start_i = 1'b1;
    bin_i   = 16'd1111;
    tick();
    start_i = 1'b0;
    wait_done(lat, bn);
    chk("ign_lat", 32'(lat), 32'd16);
    chk("ign_bcd", 32'(bcd_o), 32'h04321);
    tick();
    chk("ign_no_extra_busy", 32'(busy_o), 32'd0);

    // Reset in the middle of a conversion.
    accept(16'd2468);
    tick(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_bcd",  32'(bcd_o),  32'd0);
    chk("midrst_neg",  32'(neg_o),  32'd0);
    seen = 0;
    repeat (30) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    // Decade boundaries and sign-edge values.
    edges = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000,
              16'd9999, 16'd10000, 16'd32767, 16'd32768, 16'd32769,
              16'd59999, 16'd65534, 16'd65535};
    for (int i = 0; i < 16; i++) convert_check(edges[i]);

    // Random sample across the full input range.
    for (int i = 0; i < 150; i++) convert_check(16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
